countdown_display_driver: RTL and testbench

COUNTDOWN_DISPLAY_DRIVER -- requirements
Module: countdown_display_driver

---
 rtl/countdown_display_driver_pkg.sv | 27 ++
 rtl/bin7_to_bcd_serial.sv | 69 ++++++
 rtl/countdown_display_driver.sv | 123 ++++++++++++
 tb/tb_countdown_display_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_display_driver_pkg.sv
// Shared converter states, digit-select constants and 7-segment patterns
// for countdown_display_driver and its BCD converter.
package countdown_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD
  } conv_state_t;

  localparam logic       DIGIT_ONES = 1'b0;
  localparam logic       DIGIT_TENS = 1'b1;
  localparam logic [1:0] AN_ONES    = 2'b01;
  localparam logic [1:0] AN_TENS    = 2'b10;
  localparam logic [6:0] SEG_OFF    = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; entry 9 first so index n gives digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_OFF;
  endfunction

endpackage

// File: rtl/bin7_to_bcd_serial.sv
// Serial shift-add-3 converter: 7-bit binary (clamped to 99) to two BCD digits.
// IDLE -> CONVERT (7 shift cycles) -> LOAD (update outputs) -> IDLE.
module bin7_to_bcd_serial
  import countdown_display_driver_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic       o_busy,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  conv_state_t r_state;
  logic [14:0] r_shift;   // {tens, ones, remaining binary bits}
  logic [2:0]  r_cnt;
  logic [7:0]  w_adj;
  logic [6:0]  w_clamped;

  assign w_clamped = (i_bin > 7'd99) ? 7'd99 : i_bin;

  for (genvar gi = 0; gi < 2; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_shift[7 + gi*4 +: 4] >= 4'd5) ?
                              r_shift[7 + gi*4 +: 4] + 4'd3 :
                              r_shift[7 + gi*4 +: 4];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_tens  <= '0;
      o_ones  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= {8'd0, w_clamped};
            r_cnt   <= '0;
            r_state <= ST_CONVERT;
            o_busy  <= 1'b1;
          end
        end
        ST_CONVERT: begin
          // Tens never reaches 5 before the final shift, so w_adj[7] is always 0.
          r_shift <= {w_adj[6:0], r_shift[6:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_tens  <= r_shift[14:11];
          o_ones  <= r_shift[10:7];
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/countdown_display_driver.sv
// Two-digit multiplexed 7-segment driver for the traffic-light countdown.
// Optional yellow blink enabled by defining DISP_YELLOW_BLINK_EN.
module countdown_display_driver
  import countdown_display_driver_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_value,
  input  logic [2:0] i_led,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_busy
);

  localparam int         SCAN_W      = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_ALL_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0]        r_value_in;
  logic [6:0]        r_last;
  logic              w_busy;
  logic              w_start;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_digit;
  logic [6:0]        w_seg_lit;
  logic              w_force_off;

  // Input is registered first; the comparison against the last accepted
  // value happens one edge later, only while the converter is idle.
  assign w_start = !w_busy && (r_value_in != r_last);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_value_in <= '0;
      r_last     <= '0;
    end else begin
      r_value_in <= i_value;
      if (w_start) begin
        r_last <= r_value_in;
      end
    end
  end

  bin7_to_bcd_serial u_bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_bin   (r_value_in),
    .o_busy  (w_busy),
    .o_tens  (w_tens),
    .o_ones  (w_ones)
  );

  assign o_busy = w_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_digit    <= DIGIT_ONES;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= ~r_digit;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

`ifdef DISP_YELLOW_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;
  logic               w_yellow;

  assign w_yellow = (i_led == 3'b010);

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_yellow) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_force_off = w_yellow && !r_blink_on;
`else
  localparam int BLINK_DIV_UNUSED = BLINK_DIV;
  logic w_unused_led;
  assign w_unused_led = ^i_led;
  assign w_force_off  = 1'b0;
`endif

  // Tens digit is blanked when zero; ones digit always shows.
  always_comb begin
    w_seg_lit = seg_of(w_ones);
    if (r_digit == DIGIT_TENS) begin
      w_seg_lit = (w_tens == 4'd0) ? SEG_OFF : seg_of(w_tens);
    end
    if (w_force_off) begin
      w_seg_lit = SEG_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_an  <= 2'b00;
      o_seg <= SEG_ALL_OFF;
    end else begin
      o_an  <= (r_digit == DIGIT_TENS) ? AN_TENS : AN_ONES;
      o_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
    end
  end

endmodule

// File: tb/tb_countdown_display_driver.sv
// Randomized self-checking bench for countdown_display_driver against a
// decimal-level reference model (SCAN_DIV=4, BLINK_DIV=16, active-high segments).
module tb_countdown_display_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] value = 7'd0;
  logic [2:0] led   = 3'b001;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last  = 0;  // last i_value the converter accepted
  int model_shown = 0;  // decimal number the BCD registers should hold

  always #5 clk = ~clk;

  countdown_display_driver #(
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_DIV      (BLINK_DIV),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_value (value),
    .i_led   (led),
    .o_seg   (seg),
    .o_an    (an),
    .o_busy  (busy)
  );

  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int bcd_now();
    return int'(dut.u_bcd.o_tens) * 10 + int'(dut.u_bcd.o_ones);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Two full scan periods: every sample must show the right digit pattern.
  task automatic check_display(input string tag, input int shown);
    int tens = shown / 10;
    int ones = shown % 10;
    int n_ones = 0;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      if (an == 2'b10) begin
        check({tag, "_tens"}, int'(seg), (tens == 0) ? 0 : int'(pattern(tens)));
      end else begin
        n_ones++;
        check({tag, "_ones"}, int'({an, seg}), int'({2'b01, pattern(ones)}));
      end
    end
    check({tag, "_slots"}, n_ones, 2 * SCAN_DIV);
  endtask

  task automatic apply_value(input int v);
    int clamped    = (v > 99) ? 99 : v;
    bit changed    = (v != model_last);
    int exp_before = model_shown;
    int exp_after  = changed ? clamped : model_shown;
    int n_busy     = 0;
    int first_busy = -1;
    value = 7'(v);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = k;
      end
      if (k == 9)  check("bcd_hold", bcd_now(), exp_before);
      if (k == 10) check("bcd_update", bcd_now(), exp_after);
    end
    check("busy_cycles", n_busy, changed ? 8 : 0);
    if (changed) check("busy_start", first_busy, 2);
    model_last  = v;
    model_shown = exp_after;
    $display("apply value=%0d changed=%0d busy_cycles=%0d shown=%0d", v, changed, n_busy, model_shown);
    check_display("disp", model_shown);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_busy;

    // Reset state, then the one idle cycle and the blank tens slot for 0.
    repeat (3) @(negedge clk);
    check("rst_an", int'(an), 0);
    check("rst_seg", int'(seg), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("first_ones", int'({an, seg}), int'({2'b01, 7'h3F}));
    $display("reset released value=0");
    check_display("zero", 0);

    apply_value(10);
    apply_value(127);
    apply_value(99);

    // 7 then 3 two cycles later: both convert, 3 after 7 finishes.
    value  = 7'd7;
    n_busy = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (k == 2)  value = 7'd3;
      if (k == 10) check("seq_bcd7", bcd_now(), 7);
      if (k == 10) check("seq_gap", int'(busy), 0);
      if (k == 18) check("seq_hold7", bcd_now(), 7);
      if (k == 19) check("seq_bcd3", bcd_now(), 3);
    end
    check("seq_busy", n_busy, 16);
    model_last  = 3;
    model_shown = 3;
    $display("sequence 7 then 3 busy_cycles=%0d", n_busy);
    check_display("seq73", 3);

    // Reset in the 3rd CONVERT cycle of 55 aborts without any load.
    value = 7'd55;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check("abort_busy_pre", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_an", int'(an), 0);
    check("abort_seg", int'(seg), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b0;
    value = 7'd0;
    model_last  = 0;
    model_shown = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("abort_no_load", bcd_now(), 0);
      check("abort_idle", int'(busy), 0);
    end
    $display("reset abort during conversion of 55");
    check_display("abort", 0);

    for (int i = 0; i < 12; i++) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? model_last : int'($urandom_range(0, 127));
      apply_value(v);
    end

`ifdef DISP_YELLOW_BLINK_EN
    apply_value(88);
    led = 3'b010;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check("blink_yellow", int'(seg), (((k - 1) / BLINK_DIV) % 2 == 1) ? 0 : 'h7F);
    end
    $display("yellow blink checked over 64 cycles");
    led = 3'b001;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("steady_red", int'(seg), 'h7F);
    end
    $display("red steady checked over 32 cycles");
`else
    apply_value(88);
    led = 3'b010;
    check_display("led_yellow_ignored", 88);
    led = 3'b100;
    check_display("led_green_ignored", 88);
    $display("i_led changes have no effect on display");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
